// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transceiver slice.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  localparam int unsigned MIN_DIV = 3;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO, 2**AW entries, extra pointer MSB for full/empty.
module uart_sync_fifo #(
  parameter int unsigned W  = 8,
  parameter int unsigned AW = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  output logic         full,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         empty
);

  logic [W-1:0] mem [2**AW];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         push;
  logic         pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_xcvr_fifo.sv
// Full-duplex UART with TX/RX FIFOs, runtime divisor, parity and 1/2 stop bits.
// Optional UART_LOOPBACK_EN adds loopback_i: RX fed from the TX line, ser_tx pin held high.
module uart_xcvr_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned FIFO_AW = 3,
  parameter int unsigned DIV_W   = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              two_stop,
`ifdef UART_LOOPBACK_EN
  input  logic              loopback_i,
`endif
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              ser_tx,
  input  logic              ser_rx,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              rx_done,
  output logic              rx_frame_err,
  output logic              rx_parity_err,
  output logic              rx_overrun
);

  localparam int unsigned BW = $clog2(DATA_W + 3);

  logic [DIV_W-1:0] div_eff;
  assign div_eff = (clk_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : clk_div;

  // ---------------- TX ----------------
  tx_state_e         tx_state, tx_nxt;
  logic [DIV_W-1:0]  tx_cnt, tx_div_q;
  logic [BW-1:0]     tx_bit;
  logic [DATA_W-1:0] tx_shift, txf_data;
  logic              tx_par_q, tx_pen_q, tx_two_q;
  logic              tx_pop, tx_fin, tx_line, tx_tick, txf_full, txf_empty;

  uart_sync_fifo #(.W(DATA_W), .AW(FIFO_AW)) u_tx_fifo (
    .clk(wb_clk_i), .rst(wb_rst_i),
    .wr_en(tx_valid), .wr_data(tx_data), .full(txf_full),
    .rd_en(tx_pop), .rd_data(txf_data), .empty(txf_empty)
  );

  assign tx_ready = !txf_full;
  assign tx_busy  = (tx_state != TX_IDLE) || !txf_empty;
  assign tx_tick  = (tx_cnt == '0);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) tx_state <= TX_IDLE;
    else          tx_state <= tx_nxt;
  end

  // The final stop bit pops the next word directly so frames run back to back.
  always_comb begin
    tx_nxt  = tx_state;
    tx_pop  = 1'b0;
    tx_fin  = 1'b0;
    tx_line = 1'b1;
    case (tx_state)
      TX_IDLE: if (!txf_empty) begin
        tx_pop = 1'b1;
        tx_nxt = TX_START;
      end
      TX_START: begin
        tx_line = 1'b0;
        if (tx_tick) tx_nxt = TX_DATA;
      end
      TX_DATA: begin
        tx_line = tx_shift[0];
        if (tx_tick && tx_bit == BW'(DATA_W - 1)) tx_nxt = tx_pen_q ? TX_PARITY : TX_STOP;
      end
      TX_PARITY: begin
        tx_line = tx_par_q;
        if (tx_tick) tx_nxt = TX_STOP;
      end
      TX_STOP: if (tx_tick && (!tx_two_q || tx_bit == BW'(1))) begin
        tx_fin = 1'b1;
        if (!txf_empty) begin
          tx_pop = 1'b1;
          tx_nxt = TX_START;
        end else begin
          tx_nxt = TX_IDLE;
        end
      end
      default: tx_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tx_cnt   <= '0;
      tx_div_q <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_par_q <= 1'b0;
      tx_pen_q <= 1'b0;
      tx_two_q <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= tx_fin;
      if (tx_pop) begin
        tx_shift <= txf_data;
        tx_div_q <= div_eff;
        tx_cnt   <= div_eff;
        tx_par_q <= (^txf_data) ^ parity_odd;
        tx_pen_q <= parity_en;
        tx_two_q <= two_stop;
        tx_bit   <= '0;
      end else if (tx_state != TX_IDLE) begin
        if (tx_tick) begin
          tx_cnt <= tx_div_q;
          tx_bit <= (tx_nxt != tx_state) ? '0 : tx_bit + 1'b1;
          if (tx_state == TX_DATA) tx_shift <= tx_shift >> 1;
        end else begin
          tx_cnt <= tx_cnt - 1'b1;
        end
      end
    end
  end

  // ---------------- RX ----------------
  rx_state_e         rx_state, rx_nxt;
  logic [DIV_W-1:0]  rx_cnt, rx_div_q;
  logic [BW-1:0]     rx_bit;
  logic [DATA_W-1:0] rx_shift;
  logic              rx_s1, rx_s2, rx_in, rx_prev, rx_tick;
  logic              rx_odd_q, rx_pen_q, rx_perr_q, rxf_full, rxf_empty;
  logic              rx_start, rx_push, fe, pe, ov;

`ifdef UART_LOOPBACK_EN
  assign ser_tx = loopback_i ? 1'b1 : tx_line;
  assign rx_in  = loopback_i ? tx_line : rx_s2;
`else
  assign ser_tx = tx_line;
  assign rx_in  = rx_s2;
`endif

  uart_sync_fifo #(.W(DATA_W), .AW(FIFO_AW)) u_rx_fifo (
    .clk(wb_clk_i), .rst(wb_rst_i),
    .wr_en(rx_push), .wr_data(rx_shift), .full(rxf_full),
    .rd_en(rx_ready), .rd_data(rx_data), .empty(rxf_empty)
  );

  assign rx_valid = !rxf_empty;
  assign rx_tick  = (rx_cnt == '0);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rx_state <= RX_IDLE;
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
    end else begin
      rx_state <= rx_nxt;
      rx_s1    <= ser_rx;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_in;
    end
  end

  always_comb begin
    rx_nxt   = rx_state;
    rx_start = 1'b0;
    rx_push  = 1'b0;
    fe       = 1'b0;
    pe       = 1'b0;
    ov       = 1'b0;
    case (rx_state)
      RX_IDLE: if (rx_prev && !rx_in) begin
        rx_start = 1'b1;
        rx_nxt   = RX_START;
      end
      RX_START: if (rx_tick) rx_nxt = rx_in ? RX_IDLE : RX_DATA;
      RX_DATA: if (rx_tick && rx_bit == BW'(DATA_W - 1)) rx_nxt = rx_pen_q ? RX_PARITY : RX_STOP;
      RX_PARITY: if (rx_tick) rx_nxt = RX_STOP;
      RX_STOP: if (rx_tick) begin
        rx_nxt = RX_IDLE;
        if (!rx_in)         fe      = 1'b1;
        else if (rx_perr_q) pe      = 1'b1;
        else if (rxf_full)  ov      = 1'b1;
        else                rx_push = 1'b1;
      end
      default: rx_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rx_cnt        <= '0;
      rx_div_q      <= '0;
      rx_bit        <= '0;
      rx_shift      <= '0;
      rx_odd_q      <= 1'b0;
      rx_pen_q      <= 1'b0;
      rx_perr_q     <= 1'b0;
      rx_done       <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_done       <= rx_push;
      rx_frame_err  <= fe;
      rx_parity_err <= pe;
      rx_overrun    <= ov;
      if (rx_start) begin
        rx_div_q  <= div_eff;
        rx_cnt    <= div_eff >> 1;
        rx_odd_q  <= parity_odd;
        rx_pen_q  <= parity_en;
        rx_perr_q <= 1'b0;
        rx_bit    <= '0;
      end else if (rx_state != RX_IDLE) begin
        if (rx_tick) begin
          rx_cnt <= rx_div_q;
          rx_bit <= (rx_nxt != rx_state) ? '0 : rx_bit + 1'b1;
          if (rx_state == RX_DATA)   rx_shift  <= {rx_in, rx_shift[DATA_W-1:1]};
          if (rx_state == RX_PARITY) rx_perr_q <= rx_in ^ (^rx_shift) ^ rx_odd_q;
        end else begin
          rx_cnt <= rx_cnt - 1'b1;
        end
      end
    end
  end

endmodule
